// File: rtl/fwd_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// fwd_hazard_ctrl
//
// Control-side producer of the EX-stage operand-forwarding selects plus the
// load-use stall and branch-flush controls for the IF/ID/EX stages.
//
// The block keeps a shadow copy of the EX and MEM pipeline entries
// ({rd, wren, load}) so it can compare the sources of the instruction in ID
// against the destinations of older in-flight instructions. The selects are
// registered so they line up with the instruction as it enters EX.
//
// Select encoding (o_opa_sel / o_opb_sel):
//   00 register-file data, 01 WB-mux data, 10 ALU/MEM-stage data, 11 unused
//
// Parameters:
//   REG_AW  register address width
//   CNT_W   width of the optional stall counter
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_id_*                 ID-stage instruction fields (valid, sources,
//                          source-used flags, destination, write enable, load)
//   i_ex_br_taken          EX resolved a taken branch/jump (redirect)
//   o_opa_sel, o_opb_sel   registered forwarding selects for the EX operand
//   o_stall_if, o_stall_id hold PC / hold IF/ID on a load-use hazard
//   o_flush_id             squash IF/ID on a redirect
//   o_flush_ex             load a bubble into ID/EX (load-use or redirect)
//   o_stall_cnt            (only with FWD_HAZARD_STALL_CNT_EN) count of
//                          load-use stall cycles, wraps modulo 2^CNT_W
//
// Optional feature macro: FWD_HAZARD_STALL_CNT_EN
// ---------------------------------------------------------------------------
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_id_valid,
  input  logic [REG_AW-1:0] i_id_rs1_addr,
  input  logic [REG_AW-1:0] i_id_rs2_addr,
  input  logic              i_id_rs1_used,
  input  logic              i_id_rs2_used,
  input  logic [REG_AW-1:0] i_id_rd_addr,
  input  logic              i_id_rd_wren,
  input  logic              i_id_mem_rden,
  input  logic              i_ex_br_taken,
  output logic [1:0]        o_opa_sel,
  output logic [1:0]        o_opb_sel,
  output logic              o_stall_if,
  output logic              o_stall_id,
  output logic              o_flush_id,
`ifdef FWD_HAZARD_STALL_CNT_EN
  output logic              o_flush_ex,
  output logic [CNT_W-1:0]  o_stall_cnt
`else
  output logic              o_flush_ex
`endif
);

  typedef enum logic [1:0] {
    SEL_RF = 2'b00,
    SEL_WB = 2'b01,
    SEL_EX = 2'b10
  } sel_e;

  // Shadow EX entry carries the load flag; MEM only needs rd/wren because
  // a load that has reached MEM is forwarded from WB like any other result.
  logic [REG_AW-1:0] ex_rd;
  logic              ex_wren;
  logic              ex_load;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_wren;

  logic              rs1_ex_hit;
  logic              rs2_ex_hit;
  logic              rs1_mem_hit;
  logic              rs2_mem_hit;
  logic              load_use;
  logic              flush;
  logic              stall;
  logic              bubble;
  sel_e              opa_next;
  sel_e              opb_next;

  function automatic logic src_match(
    input logic [REG_AW-1:0] rs,
    input logic              used,
    input logic [REG_AW-1:0] rd,
    input logic              wren
  );
    return used && (rs != '0) && wren && (rd == rs);
  endfunction

  function automatic sel_e pick_sel(input logic ex_hit, input logic mem_hit);
    // Newest producer wins: EX has priority over MEM.
    if (ex_hit)       return SEL_EX;
    else if (mem_hit) return SEL_WB;
    else              return SEL_RF;
  endfunction

  always_comb begin
    rs1_ex_hit  = src_match(i_id_rs1_addr, i_id_rs1_used, ex_rd,  ex_wren);
    rs2_ex_hit  = src_match(i_id_rs2_addr, i_id_rs2_used, ex_rd,  ex_wren);
    rs1_mem_hit = src_match(i_id_rs1_addr, i_id_rs1_used, mem_rd, mem_wren);
    rs2_mem_hit = src_match(i_id_rs2_addr, i_id_rs2_used, mem_rd, mem_wren);

    load_use = i_id_valid && ex_load && (rs1_ex_hit || rs2_ex_hit);

    // Gated by reset so every control output drops the moment reset asserts.
    flush = i_rst_n && i_ex_br_taken;
    stall = i_rst_n && load_use && !i_ex_br_taken;

    // Whatever enters shadow EX this edge is a bubble if it is squashed,
    // held back in ID, or not a real instruction.
    bubble = flush || stall || !i_id_valid;

    opa_next = SEL_RF;
    opb_next = SEL_RF;
    if (!bubble) begin
      opa_next = pick_sel(rs1_ex_hit, rs1_mem_hit);
      opb_next = pick_sel(rs2_ex_hit, rs2_mem_hit);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_rd     <= '0;
      ex_wren   <= 1'b0;
      ex_load   <= 1'b0;
      mem_rd    <= '0;
      mem_wren  <= 1'b0;
      o_opa_sel <= SEL_RF;
      o_opb_sel <= SEL_RF;
    end else begin
      mem_rd   <= ex_rd;
      mem_wren <= ex_wren;
      if (bubble) begin
        ex_rd   <= '0;
        ex_wren <= 1'b0;
        ex_load <= 1'b0;
      end else begin
        ex_rd   <= i_id_rd_addr;
        ex_wren <= i_id_rd_wren;
        ex_load <= i_id_mem_rden;
      end
      o_opa_sel <= opa_next;
      o_opb_sel <= opb_next;
    end
  end

  always_comb begin
    o_stall_if = stall;
    o_stall_id = stall;
    o_flush_id = flush;
    o_flush_ex = stall || flush;
  end

`ifdef FWD_HAZARD_STALL_CNT_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      o_stall_cnt <= '0;
    else if (stall)
      o_stall_cnt <= o_stall_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  localparam int unsigned NV = 17;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, rd_wren, mem_rden;
  logic       br_taken;
  logic [1:0] opa_sel, opb_sel;
  logic       stall_if, stall_id, flush_id, flush_ex;
`ifdef FWD_HAZARD_STALL_CNT_EN
  logic [31:0] stall_cnt;
  int unsigned exp_cnt;
`endif

  int checks;
  int errors;

  fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(32)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_id_valid    (id_valid),
    .i_id_rs1_addr (rs1),
    .i_id_rs2_addr (rs2),
    .i_id_rs1_used (rs1_used),
    .i_id_rs2_used (rs2_used),
    .i_id_rd_addr  (rd),
    .i_id_rd_wren  (rd_wren),
    .i_id_mem_rden (mem_rden),
    .i_ex_br_taken (br_taken),
    .o_opa_sel     (opa_sel),
    .o_opb_sel     (opb_sel),
    .o_stall_if    (stall_if),
    .o_stall_id    (stall_id),
    .o_flush_id    (flush_id),
`ifdef FWD_HAZARD_STALL_CNT_EN
    .o_flush_ex    (flush_ex),
    .o_stall_cnt   (stall_cnt)
`else
    .o_flush_ex    (flush_ex)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [4:0] rs1;
    logic       u1;
    logic [4:0] rs2;
    logic       u2;
    logic [4:0] rd;
    logic       wr;
    logic       ld;
    logic       br;
    logic       stall;
    logic       fid;
    logic       fex;
    logic [1:0] opa;
    logic [1:0] opb;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic v, input logic [4:0] a1, input logic u1,
    input logic [4:0] a2, input logic u2, input logic [4:0] d,
    input logic wr, input logic ld, input logic br,
    input logic st, input logic fid, input logic fex,
    input logic [1:0] opa, input logic [1:0] opb);
    vec_t r;
    r.valid = v; r.rs1 = a1; r.u1 = u1; r.rs2 = a2; r.u2 = u2;
    r.rd = d; r.wr = wr; r.ld = ld; r.br = br;
    r.stall = st; r.fid = fid; r.fex = fex; r.opa = opa; r.opb = opb;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.valid; rs1 = v.rs1; rs1_used = v.u1; rs2 = v.rs2; rs2_used = v.u2;
    rd = v.rd; rd_wren = v.wr; mem_rden = v.ld; br_taken = v.br;
  endtask

  task automatic check_ctrl(input string tag, input logic st, input logic fid, input logic fex);
    chk({tag, ".stall_if"}, {31'd0, stall_if}, {31'd0, st});
    chk({tag, ".stall_id"}, {31'd0, stall_id}, {31'd0, st});
    chk({tag, ".flush_id"}, {31'd0, flush_id}, {31'd0, fid});
    chk({tag, ".flush_ex"}, {31'd0, flush_ex}, {31'd0, fex});
  endtask

  task automatic check_sel(input string tag, input logic [1:0] a, input logic [1:0] b);
    chk({tag, ".opa_sel"}, {30'd0, opa_sel}, {30'd0, a});
    chk({tag, ".opb_sel"}, {30'd0, opb_sel}, {30'd0, b});
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
`ifdef FWD_HAZARD_STALL_CNT_EN
    exp_cnt = 0;
`endif
    //            v  rs1 u1 rs2 u2 rd  wr ld br  st fid fex opa    opb
    vecs[0]  = mk(1, 0,  1, 0,  0, 5,  1, 0, 0,  0, 0,  0,  2'b00, 2'b00); // addi x5
    vecs[1]  = mk(1, 1,  1, 2,  1, 12, 1, 0, 0,  0, 0,  0,  2'b00, 2'b00); // unrelated
    vecs[2]  = mk(1, 3,  1, 5,  1, 13, 1, 0, 0,  0, 0,  0,  2'b00, 2'b01); // distance-2 rs2=x5
    vecs[3]  = mk(1, 13, 1, 7,  1, 6,  1, 0, 0,  0, 0,  0,  2'b10, 2'b00); // back-to-back rs1
    vecs[4]  = mk(1, 0,  0, 0,  0, 5,  1, 0, 0,  0, 0,  0,  2'b00, 2'b00); // x5 producer A
    vecs[5]  = mk(1, 0,  0, 0,  0, 5,  1, 0, 0,  0, 0,  0,  2'b00, 2'b00); // x5 producer B
    vecs[6]  = mk(1, 5,  1, 0,  0, 14, 1, 0, 0,  0, 0,  0,  2'b10, 2'b00); // newest wins
    vecs[7]  = mk(1, 0,  0, 0,  0, 0,  1, 0, 0,  0, 0,  0,  2'b00, 2'b00); // write x0
    vecs[8]  = mk(1, 0,  1, 0,  1, 15, 1, 0, 0,  0, 0,  0,  2'b00, 2'b00); // read x0
    vecs[9]  = mk(0, 15, 1, 0,  0, 16, 1, 0, 0,  0, 0,  0,  2'b00, 2'b00); // invalid ID
    vecs[10] = mk(1, 16, 1, 15, 1, 0,  0, 0, 0,  0, 0,  0,  2'b00, 2'b01); // invalid was bubble
    vecs[11] = mk(1, 1,  1, 0,  0, 8,  1, 1, 0,  0, 0,  0,  2'b00, 2'b00); // lw x8
    vecs[12] = mk(1, 8,  1, 1,  1, 9,  1, 0, 0,  1, 0,  1,  2'b00, 2'b00); // load-use stall
    vecs[13] = mk(1, 8,  1, 1,  1, 9,  1, 0, 0,  0, 0,  0,  2'b01, 2'b00); // consumer replays
    vecs[14] = mk(1, 0,  0, 0,  0, 8,  1, 1, 0,  0, 0,  0,  2'b00, 2'b00); // lw x8
    vecs[15] = mk(1, 8,  1, 0,  0, 9,  1, 0, 1,  0, 1,  1,  2'b00, 2'b00); // load-use + redirect
    vecs[16] = mk(1, 8,  1, 0,  0, 20, 1, 0, 0,  0, 0,  0,  2'b01, 2'b00); // lw now in MEM

    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
    drive(idle);
    rst_n = 1'b0;
    #12;
    check_ctrl("reset", 1'b0, 1'b0, 1'b0);
    check_sel("reset", 2'b00, 2'b00);
`ifdef FWD_HAZARD_STALL_CNT_EN
    chk("reset.stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #2;
      check_ctrl($sformatf("vec%0d", i), vecs[i].stall, vecs[i].fid, vecs[i].fex);
      @(posedge clk);
      #1;
      check_sel($sformatf("vec%0d", i), vecs[i].opa, vecs[i].opb);
`ifdef FWD_HAZARD_STALL_CNT_EN
      if (vecs[i].stall) exp_cnt++;
      chk($sformatf("vec%0d.stall_cnt", i), stall_cnt, exp_cnt);
`endif
      @(negedge clk);
    end

    // Reset dropped in the middle of a load-use stall.
    // lw x8 reads x20 produced by vec16 (now in EX) -> forwarded from EX.
    drive(mk(1, 20, 1, 0, 0, 8, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00));
    @(posedge clk);
    #1;
    check_sel("rst_pre", 2'b10, 2'b00);
    @(negedge clk);
    drive(mk(1, 8, 1, 0, 0, 9, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    #2;
    check_ctrl("rst_stall", 1'b1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_ctrl("rst_async", 1'b0, 1'b0, 1'b0);
    check_sel("rst_async", 2'b00, 2'b00);
`ifdef FWD_HAZARD_STALL_CNT_EN
    exp_cnt = 0;
    chk("rst_async.stall_cnt", stall_cnt, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check_ctrl("rst_post", 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_sel("rst_post", 2'b00, 2'b00);
`ifdef FWD_HAZARD_STALL_CNT_EN
    chk("rst_post.stall_cnt", stall_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side producer of the EX-stage operand-forwarding selects `opa_sel`/`opb_sel`.
  - Encoding: 00 = register-file data, 01 = WB-mux data, 10 = ALU/MEM-stage data, 11 = unused (EX drives 0).
- Tracks destination registers of in-flight instructions in internal shadow EX/MEM stages.
- Registers the forwarding selects so they arrive alongside the instruction entering EX.
- Generates the load-use stall and branch flush controls for IF/ID/EX.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the optional stall counter.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs1_addr  in  REG_AW  ID source 1
- i_id_rs2_addr  in  REG_AW  ID source 2
- i_id_rs1_used  in  1  instruction reads rs1
- i_id_rs2_used  in  1  instruction reads rs2
- i_id_rd_addr  in  REG_AW  ID destination
- i_id_rd_wren  in  1  instruction writes rd
- i_id_mem_rden  in  1  instruction is a load
- i_ex_br_taken  in  1  EX resolved taken branch/jump (redirect)
- o_opa_sel  out  2  operand A select for the instruction now in EX
- o_opb_sel  out  2  operand B select for the instruction now in EX
- o_stall_if  out  1  hold PC
- o_stall_id  out  1  hold IF/ID register
- o_flush_id  out  1  squash IF/ID register
- o_flush_ex  out  1  load bubble into ID/EX register

Behaviour:
- Single clock i_clk; reset i_rst_n is asynchronous, active-low.
- Reset state:
  - Shadow EX and MEM entries are invalid: rd = 0, wren = 0, load = 0.
  - o_opa_sel = o_opb_sel = 00.
  - All stall/flush outputs = 0.
- Shadow pipeline: each entry holds {rd, wren, load}. On every clock edge, MEM <= EX and EX <= incoming ID entry or a bubble.
- Hazard terms, combinational on the current cycle:
  - `match_ex(rs)` = rs_used && rs != 0 && EX.wren && EX.rd == rs.
  - `match_mem(rs)` = rs_used && rs != 0 && MEM.wren && MEM.rd == rs.
  - `load_use` = i_id_valid && EX.load && (match_ex(rs1) || match_ex(rs2)).
- Next select per operand, registered into o_opX_sel at the edge:
  - match_ex → 10 (the producer will be in MEM when the consumer is in EX).
  - else match_mem → 01 (the producer will be in WB).
  - else 00.
  - Newest producer wins: EX beats MEM.
  - x0 is never forwarded.
  - Register-file write-first covers the 3-deep distance, so no third forwarding level is needed.
- Load-use (and no flush):
  - o_stall_if = o_stall_id = o_flush_ex = 1 for exactly one cycle.
  - Shadow EX <= bubble; both selects <= 00.
  - Next cycle the load sits in shadow MEM; the consumer re-evaluates with match_mem → 01.
- Branch flush (i_ex_br_taken = 1):
  - o_flush_id = o_flush_ex = 1, stall outputs = 0.
  - Shadow EX <= bubble; selects <= 00.
  - Flush overrides a simultaneous load-use.
- i_id_valid = 0: the incoming entry is treated as a bubble (wren = 0, load = 0) and the selects are 00.
- Stall/flush outputs are combinational from the current shadow state and ID inputs; there is no added latency.
- Reset asserted mid-stall clears everything immediately. The first post-reset cycle produces no stall.

Optional Feature:
- Macro: `FWD_HAZARD_STALL_CNT_EN`.
- Defined:
  - Adds output port o_stall_cnt (CNT_W bits), reset to 0.
  - Increments by 1 on every cycle where o_stall_id = 1.
  - Wraps modulo 2^CNT_W.
  - Flush cycles are not counted.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Back-to-back ALU dependency: `addi x5` in ID (wren = 1), next cycle `add x6,x5,x7` in ID → on the following edge o_opa_sel = 10, o_opb_sel = 00, no stall.
- Distance-2 dependency: producer x5, one unrelated instruction, then consumer rs2 = x5 → o_opb_sel = 01.
- Double producer: x5 written by two consecutive instructions, consumer rs1 = x5 → o_opa_sel = 10 (newest wins).
- Load-use: `lw x8` then `add x9,x8,x1`:
  - o_stall_if/o_stall_id/o_flush_ex = 1 for exactly 1 cycle.
  - The consumer then enters EX with o_opa_sel = 01.
  - With `FWD_HAZARD_STALL_CNT_EN`, o_stall_cnt goes 0 → 1.
- x0 and flush priority:
  - Producer rd = x0 with consumer rs1 = x0 → sel 00.
  - Load-use coincident with i_ex_br_taken = 1 → flush outputs = 1, stall = 0, next selects 00.
- Async reset: drop i_rst_n while a stall is asserted → all outputs 0 immediately; after release, no spurious forward.
